// File: rtl/rx_fifo.sv
// Receive FIFO behind the tx_rx character receiver: captures each data_ready
// rising edge into a 16-entry (or 1-entry holding-register) first-word-fall-through buffer.
module rx_fifo (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_data_ready,
    input  logic       rx_parity_error,
    output logic       rx_read_flag,
    input  logic       fifo_en,
    input  logic       fifo_clear,
    input  logic [1:0] trigger_level,
    input  logic       rd_en,
    input  logic       ovr_clr,
    output logic [7:0] rd_data,
    output logic       rd_parity_error,
    output logic [4:0] count,
    output logic       empty,
    output logic       full,
    output logic       overrun,
    output logic       trigger_hit,
    output logic       error_in_fifo
);

    localparam int unsigned DW    = 8;
    localparam int unsigned EW    = DW + 1;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned PW    = 4;
    localparam int unsigned CW    = 5;

    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] err_cnt_q, err_cnt_d;
    logic          ovr_q, ovr_d;
    logic          rdy_q;
    logic          flag_q;
    logic          en_q;
    logic          en_vld_q;

    logic          capture_c;
    logic          flush_c;
    logic          empty_c;
    logic          full_c;
    logic          pop_c;
    logic          push_c;
    logic [EW-1:0] head_c;
    logic [CW-1:0] thr_c;

    // Edge detect, mode tracking and acknowledge pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q    <= 1'b0;
            flag_q   <= 1'b0;
            en_q     <= 1'b0;
            en_vld_q <= 1'b0;
        end else begin
            rdy_q    <= rx_data_ready;
            flag_q   <= capture_c;
            en_q     <= fifo_en;
            en_vld_q <= 1'b1;
        end
    end

    always_comb begin
        capture_c = rx_data_ready & ~rdy_q;
        // en_vld_q masks the first cycle after reset, when en_q is not yet meaningful
        flush_c   = fifo_clear | (en_vld_q & (fifo_en != en_q));
        empty_c   = (count_q == CW'(0));
        full_c    = fifo_en ? (count_q == CW'(DEPTH)) : (count_q == CW'(1));
        pop_c     = rd_en & ~empty_c & ~flush_c;
        push_c    = capture_c & (~full_c | pop_c) & ~flush_c;
        head_c    = mem_q[rd_ptr_q];
    end

    // Pointer, occupancy, flagged-entry and overrun next state
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        err_cnt_d = err_cnt_q;
        ovr_d     = ovr_q;
        if (flush_c) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            err_cnt_d = '0;
        end else begin
            if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_c)  rd_ptr_d = rd_ptr_q + PW'(1);
            unique case ({push_c, pop_c})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            err_cnt_d = err_cnt_q + CW'(push_c & rx_parity_error) - CW'(pop_c & head_c[DW]);
        end
        if (ovr_clr) ovr_d = 1'b0;
        if (capture_c & full_c & ~pop_c & ~flush_c) ovr_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            err_cnt_q <= '0;
            ovr_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_cnt_q <= err_cnt_d;
            ovr_q     <= ovr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push_c) begin
            mem_q[wr_ptr_q] <= {rx_parity_error, rx_data};
        end
    end

    always_comb begin
        unique case (trigger_level)
            2'b00:   thr_c = CW'(1);
            2'b01:   thr_c = CW'(4);
            2'b10:   thr_c = CW'(8);
            default: thr_c = CW'(14);
        endcase
    end

    assign rx_read_flag    = flag_q;
    assign rd_data         = empty_c ? '0 : head_c[DW-1:0];
    assign rd_parity_error = ~empty_c & head_c[DW];
    assign count           = count_q;
    assign empty           = empty_c;
    assign full            = full_c;
    assign overrun         = ovr_q;
    assign trigger_hit     = fifo_en ? (count_q >= thr_c) : ~empty_c;
    assign error_in_fifo   = (err_cnt_q != CW'(0));

endmodule

// File: tb/tb_rx_fifo.sv
// Self-checking bench for rx_fifo: table of push/pop/clear vectors with a
// scoreboard queue for head data, plus hand sequences for fill/wrap/mode/reset corners.
module tb_rx_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_data_ready;
    logic       rx_parity_error;
    logic       rx_read_flag;
    logic       fifo_en;
    logic       fifo_clear;
    logic [1:0] trigger_level;
    logic       rd_en;
    logic       ovr_clr;
    logic [7:0] rd_data;
    logic       rd_parity_error;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       overrun;
    logic       trigger_hit;
    logic       error_in_fifo;

    rx_fifo dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_data_ready(rx_data_ready),
        .rx_parity_error(rx_parity_error), .rx_read_flag(rx_read_flag), .fifo_en(fifo_en),
        .fifo_clear(fifo_clear), .trigger_level(trigger_level), .rd_en(rd_en),
        .ovr_clr(ovr_clr), .rd_data(rd_data), .rd_parity_error(rd_parity_error),
        .count(count), .empty(empty), .full(full), .overrun(overrun),
        .trigger_hit(trigger_hit), .error_in_fifo(error_in_fifo)
    );

    always #5 clk = ~clk;

    typedef enum logic [1:0] {OP_PUSH, OP_POP, OP_CLR} op_e;
    typedef struct {
        op_e        op;
        logic [7:0] d;
        logic       p;
        logic [4:0] cnt;
        logic       emp;
        logic       ful;
        logic       trg;
        logic       ovr;
        logic       err;
        logic       rpe;
    } vec_t;

    int total = 0;
    int bad   = 0;
    logic [8:0] sb[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic chk5(input string nm, input logic [4:0] act, input logic [4:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic check_head();
        logic [8:0] e;
        e = (sb.size() > 0) ? sb[0] : 9'h000;
        chk8("rd_data", rd_data, e[7:0]);
        chk1("rd_parity_error", rd_parity_error, e[8]);
    endtask

    task automatic do_push(input logic [7:0] d, input logic p);
        int depth;
        depth = fifo_en ? 16 : 1;
        rx_data = d;
        rx_parity_error = p;
        rx_data_ready = 1'b1;
        if (sb.size() < depth) sb.push_back({p, d});
        tick();
        chk1("read_flag_pulse", rx_read_flag, 1'b1);
        rx_data_ready = 1'b0;
        tick();
        chk1("read_flag_drop", rx_read_flag, 1'b0);
    endtask

    task automatic do_pop();
        check_head();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        if (sb.size() > 0) sb.delete(0);
    endtask

    task automatic do_clear();
        fifo_clear = 1'b1;
        tick();
        fifo_clear = 1'b0;
        sb.delete();
    endtask

    task automatic pulse_ovr_clr();
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
    endtask

    task automatic check_reset_outputs();
        chk1("rst_read_flag", rx_read_flag, 1'b0);
        chk5("rst_count", count, 5'd0);
        chk8("rst_rd_data", rd_data, 8'h00);
        chk1("rst_rd_par", rd_parity_error, 1'b0);
        chk1("rst_overrun", overrun, 1'b0);
        chk1("rst_trigger", trigger_hit, 1'b0);
        chk1("rst_err_in_fifo", error_in_fifo, 1'b0);
        chk1("rst_full", full, 1'b0);
        chk1("rst_empty", empty, 1'b1);
    endtask

    vec_t tbl[12];

    initial begin
        // fifo_en=1, trigger level 4
        tbl[0]  = '{OP_PUSH, 8'h41, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{OP_POP,  8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{OP_PUSH, 8'h10, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{OP_PUSH, 8'h55, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{OP_PUSH, 8'h20, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{OP_PUSH, 8'h30, 1'b0, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{OP_POP,  8'h00, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[7]  = '{OP_POP,  8'h00, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{OP_PUSH, 8'hA1, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{OP_PUSH, 8'hA2, 1'b0, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{OP_PUSH, 8'hA3, 1'b0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{OP_CLR,  8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0;
        rx_data = 8'h00;
        rx_data_ready = 1'b0;
        rx_parity_error = 1'b0;
        fifo_en = 1'b1;
        fifo_clear = 1'b0;
        trigger_level = 2'b01;
        rd_en = 1'b0;
        ovr_clr = 1'b0;
        repeat (3) tick();
        check_reset_outputs();
        rst_n = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 12; i++) begin
            case (tbl[i].op)
                OP_PUSH: do_push(tbl[i].d, tbl[i].p);
                OP_POP:  do_pop();
                default: do_clear();
            endcase
            chk5("tbl_count", count, tbl[i].cnt);
            chk1("tbl_empty", empty, tbl[i].emp);
            chk1("tbl_full", full, tbl[i].ful);
            chk1("tbl_trigger", trigger_hit, tbl[i].trg);
            chk1("tbl_overrun", overrun, tbl[i].ovr);
            chk1("tbl_err_in_fifo", error_in_fifo, tbl[i].err);
            chk1("tbl_rpe", rd_parity_error, tbl[i].rpe);
            check_head();
        end

        // Fill to 16 at trigger level 8, then overrun
        trigger_level = 2'b10;
        for (int i = 0; i < 16; i++) begin
            do_push(8'(8'h60 + i), 1'b0);
            if (i == 6) chk1("trig_before_8", trigger_hit, 1'b0);
            if (i == 7) chk1("trig_at_8", trigger_hit, 1'b1);
        end
        chk5("fill_count", count, 5'd16);
        chk1("fill_full", full, 1'b1);
        chk1("fill_no_ovr", overrun, 1'b0);
        do_push(8'hF0, 1'b0);
        chk1("ovr_set", overrun, 1'b1);
        chk5("ovr_count", count, 5'd16);
        check_head();
        pulse_ovr_clr();
        chk1("ovr_cleared", overrun, 1'b0);

        // Overrun set coinciding with ovr_clr: set wins
        rx_data = 8'hF1;
        rx_data_ready = 1'b1;
        ovr_clr = 1'b1;
        tick();
        chk1("ovr_set_wins", overrun, 1'b1);
        rx_data_ready = 1'b0;
        ovr_clr = 1'b0;
        tick();
        pulse_ovr_clr();
        chk1("ovr_cleared2", overrun, 1'b0);

        // Full: simultaneous capture and pop
        check_head();
        rx_data = 8'hEE;
        rx_parity_error = 1'b0;
        rx_data_ready = 1'b1;
        rd_en = 1'b1;
        tick();
        chk5("pushpop_count", count, 5'd16);
        chk1("pushpop_no_ovr", overrun, 1'b0);
        chk1("pushpop_flag", rx_read_flag, 1'b1);
        sb.delete(0);
        sb.push_back({1'b0, 8'hEE});
        rx_data_ready = 1'b0;
        rd_en = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk8("last_is_ee", rd_data, 8'hEE);
            do_pop();
        end
        chk1("drained_empty", empty, 1'b1);
        chk8("drained_rd_data", rd_data, 8'h00);

        // Mode change flushes, then holding-register mode
        do_push(8'h99, 1'b1);
        chk1("err_before_mode", error_in_fifo, 1'b1);
        fifo_en = 1'b0;
        tick();
        sb.delete();
        chk5("mode_flush_count", count, 5'd0);
        chk1("mode_flush_empty", empty, 1'b1);
        chk1("mode_flush_err", error_in_fifo, 1'b0);
        do_push(8'h11, 1'b0);
        chk1("hold_full", full, 1'b1);
        chk1("hold_trigger", trigger_hit, 1'b1);
        do_push(8'h22, 1'b0);
        chk1("hold_ovr", overrun, 1'b1);
        chk5("hold_count", count, 5'd1);
        chk8("hold_rd_data", rd_data, 8'h11);
        do_clear();
        chk5("clr_count", count, 5'd0);
        chk1("clr_keeps_ovr", overrun, 1'b1);
        pulse_ovr_clr();
        chk1("hold_ovr_cleared", overrun, 1'b0);

        // Reset mid-stream
        fifo_en = 1'b1;
        tick();
        do_push(8'h01, 1'b1);
        do_push(8'h02, 1'b0);
        do_push(8'h03, 1'b0);
        chk5("pre_rst_count", count, 5'd3);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        tick();
        sb.delete();
        rst_n = 1'b1;
        repeat (2) tick();
        do_push(8'h77, 1'b0);
        chk5("post_rst_count", count, 5'd1);
        check_head();
        chk1("post_rst_empty", empty, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
